// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: 3-stage one-level Karatsuba unsigned multiplier with a global valid/ready stall.
// Define KMUL_TAG_EN to carry a TAG_WIDTH sideband tag through the pipeline with each operation.
module karatsuba_mult_pipe #(
    parameter int DATA_WIDTH = 24,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
`ifdef KMUL_TAG_EN
    input  logic [TAG_WIDTH-1:0]    tag_in,
    output logic [TAG_WIDTH-1:0]    tag_out,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] multi_out
);

    localparam int LW = (DATA_WIDTH + 1) / 2;
    localparam int HW = DATA_WIDTH - LW;
    localparam int ZW = 2 * LW + 2;
    localparam int PW = 2 * DATA_WIDTH;

    // The exact product always fits PW bits, so the whole recombination can run modulo 2^PW.
    function automatic logic [PW-1:0] karatsuba_combine(
        input logic [2*LW-1:0] z0,
        input logic [ZW-1:0]   z1,
        input logic [2*HW-1:0] z2
    );
        logic [PW-1:0] zm;
        zm = PW'(z1) - PW'(z0) - PW'(z2);
        return (PW'(z2) << (2 * LW)) + (zm << LW) + PW'(z0);
    endfunction

    logic              adv;
    logic              vld_p1, vld_p2, vld_p3;
    logic [LW-1:0]     a_lo_p1, b_lo_p1;
    logic [HW-1:0]     a_hi_p1, b_hi_p1;
    logic [LW:0]       sa_p1, sb_p1;
    logic [2*LW-1:0]   z0_p2;
    logic [ZW-1:0]     z1_p2;
    logic [2*HW-1:0]   z2_p2;
    logic [PW-1:0]     prod_p3;

    assign adv       = !vld_p3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3;
    assign multi_out = prod_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lo_p1 <= '0;
            b_lo_p1 <= '0;
            a_hi_p1 <= '0;
            b_hi_p1 <= '0;
            sa_p1   <= '0;
            sb_p1   <= '0;
            z0_p2   <= '0;
            z1_p2   <= '0;
            z2_p2   <= '0;
            prod_p3 <= '0;
        end else if (adv) begin
            // p1: split operands and form the half sums
            a_lo_p1 <= a_in[LW-1:0];
            b_lo_p1 <= b_in[LW-1:0];
            a_hi_p1 <= a_in[DATA_WIDTH-1:LW];
            b_hi_p1 <= b_in[DATA_WIDTH-1:LW];
            sa_p1   <= (LW+1)'(a_in[DATA_WIDTH-1:LW]) + (LW+1)'(a_in[LW-1:0]);
            sb_p1   <= (LW+1)'(b_in[DATA_WIDTH-1:LW]) + (LW+1)'(b_in[LW-1:0]);
            // p2: three half-width partial products
            z0_p2   <= (2*LW)'(a_lo_p1) * (2*LW)'(b_lo_p1);
            z2_p2   <= (2*HW)'(a_hi_p1) * (2*HW)'(b_hi_p1);
            z1_p2   <= ZW'(sa_p1) * ZW'(sb_p1);
            // p3: middle term and final recombination
            prod_p3 <= karatsuba_combine(z0_p2, z1_p2, z2_p2);
        end
    end

`ifdef KMUL_TAG_EN
    logic [TAG_WIDTH-1:0] tag_p1, tag_p2, tag_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_p1 <= '0;
            tag_p2 <= '0;
            tag_p3 <= '0;
        end else if (adv) begin
            tag_p1 <= tag_in;
            tag_p2 <= tag_p1;
            tag_p3 <= tag_p2;
        end
    end

    assign tag_out = tag_p3;
`else
    logic unused_tag_cfg;
    assign unused_tag_cfg = ^TAG_WIDTH;
`endif

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Bench for karatsuba_mult_pipe: directed and random traffic on a 24-bit and a 7-bit instance,
// checked against a queue of a*b products (tag checks only when KMUL_TAG_EN is defined).
module tb_karatsuba_mult_pipe;

    localparam int DW  = 24;
    localparam int DW7 = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]   a_in, b_in;
    logic [2*DW-1:0] multi_out;

    logic             flush7, in_valid7, in_ready7, out_valid7, out_ready7;
    logic [DW7-1:0]   a7, b7;
    logic [2*DW7-1:0] multi_out7;

`ifdef KMUL_TAG_EN
    logic [3:0] tag_in, tag_out, tag_in7, tag_out7;
`endif

    karatsuba_mult_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
`ifdef KMUL_TAG_EN
        .tag_in(tag_in), .tag_out(tag_out),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .multi_out(multi_out)
    );

    karatsuba_mult_pipe #(.DATA_WIDTH(DW7), .TAG_WIDTH(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .flush(flush7),
        .in_valid(in_valid7), .in_ready(in_ready7), .a_in(a7), .b_in(b7),
`ifdef KMUL_TAG_EN
        .tag_in(tag_in7), .tag_out(tag_out7),
`endif
        .out_valid(out_valid7), .out_ready(out_ready7), .multi_out(multi_out7)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] exp_q[$];
    logic            hold_pending = 1'b0;
    logic [2*DW-1:0] held_val     = '0;
    logic            accepted     = 1'b0;
    logic            stall_seen   = 1'b0;
    int              popped       = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: score the 24-bit instance at the falling edge, then return just after the rising edge.
    task automatic cyc();
        logic [2*DW-1:0] ea, eb;
        @(negedge clk);
        accepted = 1'b0;
        check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (!in_ready) stall_seen = 1'b1;
        if (hold_pending && out_valid) check("hold_stable", 64'(multi_out), 64'(held_val));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else begin
                check("product", 64'(multi_out), 64'(exp_q.pop_front()));
                popped++;
            end
        end
        hold_pending = out_valid && !out_ready;
        held_val     = multi_out;
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) begin
            ea = 48'(a_in);
            eb = 48'(b_in);
            exp_q.push_back(ea * eb);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, k, base;
        logic [DW-1:0]   ops_a[5];
        logic [DW-1:0]   ops_b[5];
        logic [2*DW-1:0] ea, eb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
        flush7 = 1'b0; in_valid7 = 1'b0; out_ready7 = 1'b1; a7 = '0; b7 = '0;
`ifdef KMUL_TAG_EN
        tag_in = '0; tag_in7 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_multi_out", 64'(multi_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Full-scale operands, 3-cycle latency
        in_valid = 1'b1; a_in = 24'hFFFFFF; b_in = 24'hFFFFFF;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("lat_early", 64'(out_valid), 64'd0);
        cyc();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("max_product", 64'(multi_out), 64'hFFFFFE000001);
        cyc();

        // Back-to-back ops land on consecutive cycles
        in_valid = 1'b1; a_in = 24'h800000; b_in = 24'h800000;
        cyc();
        a_in = 24'h000000; b_in = 24'h123456;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("b2b_first_valid", 64'(out_valid), 64'd1);
        check("b2b_first", 64'(multi_out), 64'h400000000000);
        cyc();
        check("b2b_second_valid", 64'(out_valid), 64'd1);
        check("b2b_second", 64'(multi_out), 64'd0);
        cyc();

        // Five streamed ops with the consumer stalled on cycles 4..7
        for (int i = 0; i < 5; i++) begin
            ops_a[i] = DW'($urandom);
            ops_b[i] = DW'($urandom);
        end
        idx = 0; k = 0; base = popped; stall_seen = 1'b0;
        while ((idx < 5 || exp_q.size() > 0) && k < 40) begin
            in_valid  = (idx < 5);
            a_in      = ops_a[idx < 5 ? idx : 4];
            b_in      = ops_b[idx < 5 ? idx : 4];
            out_ready = !(k >= 4 && k <= 7);
            cyc();
            if (accepted) idx++;
            k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_emitted", 64'(popped - base), 64'd5);
        check("bp_stall_seen", 64'(stall_seen), 64'd1);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Flush with three ops in flight, output held so none can retire
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_in = DW'($urandom); b_in = DW'($urandom);
            cyc();
        end
        flush = 1'b1; out_ready = 1'b0; a_in = 24'h00ABCD; b_in = 24'h000777;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_clear", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) cyc();
        in_valid = 1'b1; a_in = 24'd1234; b_in = 24'd5678;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        ea = 48'd1234; eb = 48'd5678;
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_prod", 64'(multi_out), 64'(ea * eb));
        cyc();

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            a_in      = ($urandom % 8 == 0) ? 24'hFFFFFF : DW'($urandom);
            b_in      = ($urandom % 8 == 0) ? 24'h000000 : DW'($urandom);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            cyc();
            k++;
        end
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2); a_in = DW'($urandom) | 24'd1; b_in = DW'($urandom) | 24'd1;
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_multi_out", 64'(multi_out), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef KMUL_TAG_EN
        check("arst_tag_out", 64'(tag_out), 64'd0);
`endif
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) cyc();

        // Odd split on the 7-bit instance
        in_valid7 = 1'b1; a7 = 7'd127; b7 = 7'd127;
        cyc();
        a7 = 7'd85; b7 = 7'd42;
        cyc();
        in_valid7 = 1'b0;
        cyc();
        check("dw7_first_valid", 64'(out_valid7), 64'd1);
        check("dw7_127x127", 64'(multi_out7), 64'd16129);
        cyc();
        check("dw7_second_valid", 64'(out_valid7), 64'd1);
        check("dw7_85x42", 64'(multi_out7), 64'd3570);
        cyc();
        check("dw7_idle", 64'(out_valid7), 64'd0);

`ifdef KMUL_TAG_EN
        in_valid = 1'b1; a_in = 24'd3; b_in = 24'd2; tag_in = 4'hA;
        cyc();
        in_valid = 1'b0; tag_in = 4'h0;
        cyc();
        cyc();
        check("tag_prod", 64'(multi_out), 64'd6);
        check("tag_out", 64'(tag_out), 64'hA);
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
